// File: rtl/addsub_arbiter_if.sv
// Bundle between two requesters, the shared add/sub unit and addsub_arbiter.
// slave = arbiter view; master = requester/unit/environment view.
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_sub;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]   au_a;
    logic [WIDTH-1:0]   au_b;
    logic               au_sub;
    logic [WIDTH-1:0]   au_res;
    logic               au_cout;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_res;
    logic               rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
    logic               rsp_ovf;
`endif

    modport slave (
        input  req_valid, req_sub, req_a, req_b, au_res, au_cout, rsp_ready,
        output req_ready, au_a, au_b, au_sub, rsp_valid, rsp_res, rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
        , output rsp_ovf
`endif
    );

    modport master (
        output req_valid, req_sub, req_a, req_b, au_res, au_cout, rsp_ready,
        input  req_ready, au_a, au_b, au_sub, rsp_valid, rsp_res, rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
        , input rsp_ovf
`endif
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin share of one external add/sub unit between two ports; optional rsp_ovf via ADDSUB_ARB_OVF_EN.
// Latency: req_ready 1 cycle after req_valid in IDLE, rsp_valid EXEC_CYCLES cycles after req_ready.
// Backpressure: response held until rsp_ready of the granted port; new requests wait in place.
module addsub_arbiter #(
    parameter int WIDTH       = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    addsub_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES);
    localparam int         MSB      = WIDTH - 1;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic             winner, winner_nxt;
    logic             pick;
    logic [3:0]       cnt, cnt_nxt;
    logic [1:0]       req_ready_q, req_ready_nxt;
    logic [1:0]       rsp_valid_q, rsp_valid_nxt;
    logic [WIDTH-1:0] au_a_q, au_a_nxt;
    logic [WIDTH-1:0] au_b_q, au_b_nxt;
    logic             au_sub_q, au_sub_nxt;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_nxt;
    logic             rsp_cout_q, rsp_cout_nxt;
`ifdef ADDSUB_ARB_OVF_EN
    logic             rsp_ovf_q, rsp_ovf_nxt;
    logic             ovf_calc;
`endif

    // Tie goes to the port that did not win last; lone requester always wins.
    assign pick = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];

`ifdef ADDSUB_ARB_OVF_EN
    assign ovf_calc = (au_sub_q ? (au_a_q[MSB] != au_b_q[MSB])
                                : (au_a_q[MSB] == au_b_q[MSB]))
                      && (bus.au_res[MSB] != au_a_q[MSB]);
`endif

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        winner_nxt     = winner;
        cnt_nxt        = cnt;
        req_ready_nxt  = 2'b00;
        rsp_valid_nxt  = rsp_valid_q;
        au_a_nxt       = au_a_q;
        au_b_nxt       = au_b_q;
        au_sub_nxt     = au_sub_q;
        rsp_res_nxt    = rsp_res_q;
        rsp_cout_nxt   = rsp_cout_q;
`ifdef ADDSUB_ARB_OVF_EN
        rsp_ovf_nxt    = rsp_ovf_q;
`endif
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    winner_nxt     = pick;
                    last_grant_nxt = pick;
                    req_ready_nxt  = pick ? 2'b10 : 2'b01;
                    au_a_nxt       = pick ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
                    au_b_nxt       = pick ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
                    au_sub_nxt     = pick ? bus.req_sub[1] : bus.req_sub[0];
                    cnt_nxt        = CNT_LOAD;
                    state_nxt      = EXEC;
                end
            end
            EXEC: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    rsp_res_nxt   = bus.au_res;
                    rsp_cout_nxt  = bus.au_cout;
`ifdef ADDSUB_ARB_OVF_EN
                    rsp_ovf_nxt   = ovf_calc;
`endif
                    rsp_valid_nxt = winner ? 2'b10 : 2'b01;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[winner]) begin
                    rsp_valid_nxt = 2'b00;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            winner      <= 1'b0;
            cnt         <= 4'd0;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            au_a_q      <= '0;
            au_b_q      <= '0;
            au_sub_q    <= 1'b0;
            rsp_res_q   <= '0;
            rsp_cout_q  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            winner      <= winner_nxt;
            cnt         <= cnt_nxt;
            req_ready_q <= req_ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            au_a_q      <= au_a_nxt;
            au_b_q      <= au_b_nxt;
            au_sub_q    <= au_sub_nxt;
            rsp_res_q   <= rsp_res_nxt;
            rsp_cout_q  <= rsp_cout_nxt;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf_q   <= rsp_ovf_nxt;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.au_a      = au_a_q;
    assign bus.au_b      = au_b_q;
    assign bus.au_sub    = au_sub_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_cout  = rsp_cout_q;
`ifdef ADDSUB_ARB_OVF_EN
    assign bus.rsp_ovf   = rsp_ovf_q;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: vector table of single operations plus
// hand-written fairness, backpressure and mid-operation reset sequences.
module tb_addsub_arbiter;
    localparam int W    = 4;
    localparam int EXEC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    addsub_arbiter_if #(.WIDTH(W)) bus ();

    addsub_arbiter #(.WIDTH(W), .EXEC_CYCLES(EXEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ripple add/sub unit: A + (B or ~B) + sub.
    assign {bus.au_cout, bus.au_res} = {1'b0, bus.au_a}
                                     + {1'b0, (bus.au_sub ? ~bus.au_b : bus.au_b)}
                                     + {{W{1'b0}}, bus.au_sub};

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.req_ready == 2'b00 && n < 20);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rsp_valid == 2'b00 && n < 40);
    endtask

    task automatic set_op(input int p, input logic [3:0] a, input logic [3:0] b, input logic s);
        bus.req_a[p*W +: W] = a;
        bus.req_b[p*W +: W] = b;
        bus.req_sub[p]      = s;
    endtask

    task automatic do_op(input vec_t v, input string nm);
        int n;
        set_op(v.port, v.a, v.b, v.sub);
        bus.req_valid[v.port] = 1'b1;
        wait_rdy(n);
        chk({nm, "_grant_lat"}, n, 1);
        chk({nm, "_req_ready"}, int'(bus.req_ready), v.port ? 2 : 1);
        bus.req_valid[v.port] = 1'b0;
        wait_rsp(n);
        chk({nm, "_exec_lat"}, n, EXEC);
        chk({nm, "_ready_pulse"}, int'(bus.req_ready), 0);
        chk({nm, "_rsp_valid"}, int'(bus.rsp_valid), v.port ? 2 : 1);
        chk({nm, "_res"}, int'(bus.rsp_res), int'(v.res));
        chk({nm, "_cout"}, int'(bus.rsp_cout), int'(v.cout));
`ifdef ADDSUB_ARB_OVF_EN
        chk({nm, "_ovf"}, int'(bus.rsp_ovf), int'(v.ovf));
`endif
        bus.rsp_ready[v.port] = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        chk({nm, "_rsp_drop"}, int'(bus.rsp_valid), 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, int'(bus.req_ready), 0);
        chk({nm, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({nm, "_rsp_res"}, int'(bus.rsp_res), 0);
        chk({nm, "_rsp_cout"}, int'(bus.rsp_cout), 0);
        chk({nm, "_au_a"}, int'(bus.au_a), 0);
        chk({nm, "_au_b"}, int'(bus.au_b), 0);
        chk({nm, "_au_sub"}, int'(bus.au_sub), 0);
`ifdef ADDSUB_ARB_OVF_EN
        chk({nm, "_rsp_ovf"}, int'(bus.rsp_ovf), 0);
`endif
    endtask

    initial begin
        int n;
        //          port  a      b     sub   res   cout  ovf
        vecs[0] = '{0, 4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{1, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0};
        vecs[2] = '{1, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0};
        vecs[3] = '{0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[4] = '{1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[5] = '{0, 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1};
        vecs[6] = '{1, 4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0};
        vecs[7] = '{0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};

        bus.req_valid = 2'b00;
        bus.req_sub   = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 2'b00;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

        // Fairness: both ports request continuously from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(0, 4'h1, 4'h2, 1'b0);
        set_op(1, 4'h9, 4'h4, 1'b1);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_rdy(n);
            chk($sformatf("alt%0d_grant", i), int'(bus.req_ready), (i % 2) ? 2 : 1);
            wait_rsp(n);
            chk($sformatf("alt%0d_rsp_valid", i), int'(bus.rsp_valid), (i % 2) ? 2 : 1);
            chk($sformatf("alt%0d_res", i), int'(bus.rsp_res), (i % 2) ? 5 : 3);
            chk($sformatf("alt%0d_cout", i), int'(bus.rsp_cout), (i % 2) ? 1 : 0);
            bus.rsp_ready = bus.rsp_valid;
            @(negedge clk);
            bus.rsp_ready = 2'b00;
        end
        bus.req_valid = 2'b00;
        @(negedge clk);

        // Backpressure on port 0 while port 1 waits; rsp_ready on port 1 must be ignored.
        set_op(0, 4'h2, 4'h2, 1'b0);
        bus.req_valid[0] = 1'b1;
        wait_rdy(n);
        chk("bp_grant0", int'(bus.req_ready), 1);
        bus.req_valid[0] = 1'b0;
        set_op(1, 4'h6, 4'h6, 1'b0);
        bus.req_valid[1] = 1'b1;
        wait_rsp(n);
        bus.rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", i), int'(bus.rsp_valid), 1);
            chk($sformatf("bp%0d_rsp_res", i), int'(bus.rsp_res), 4);
            chk($sformatf("bp%0d_req_ready", i), int'(bus.req_ready), 0);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        chk("bp_release", int'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("bp_grant1", int'(bus.req_ready), 2);
        bus.req_valid[1] = 1'b0;
        wait_rsp(n);
        chk("bp_p1_rsp_valid", int'(bus.rsp_valid), 2);
        chk("bp_p1_res", int'(bus.rsp_res), 12);
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        bus.rsp_ready = 2'b00;

        // Reset while port 1 is in EXEC; both ports then pending.
        set_op(1, 4'h3, 4'h3, 1'b0);
        bus.req_valid = 2'b10;
        wait_rdy(n);
        chk("rst_pre_grant", int'(bus.req_ready), 2);
        set_op(0, 4'h1, 4'h1, 1'b0);
        bus.req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_rsp", int'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("rst_grant0", int'(bus.req_ready), 1);
        chk("rst_no_rsp2", int'(bus.rsp_valid), 0);
        bus.req_valid[0] = 1'b0;
        wait_rsp(n);
        chk("rst_p0_rsp_valid", int'(bus.rsp_valid), 1);
        chk("rst_p0_res", int'(bus.rsp_res), 2);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        wait_rdy(n);
        chk("rst_grant1", int'(bus.req_ready), 2);
        bus.req_valid[1] = 1'b0;
        wait_rsp(n);
        chk("rst_p1_rsp_valid", int'(bus.rsp_valid), 2);
        chk("rst_p1_res", int'(bus.rsp_res), 6);
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        chk("final_idle", int'(bus.rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Shares one WIDTH-bit add/subtract unit between two requesters (port 0, port 1), using round-robin arbitration. The shared unit is instantiated outside this block. This block drives the unit's operands and mode bit, waits a fixed number of settle cycles for the ripple carry, captures the result and returns it to the granted requester over a valid/ready handshake. It sits between the datapath clients and the combinational add_sub unit.

Parameters:
WIDTH, 4, operand/result width; must match the shared unit.
EXEC_CYCLES, 1, clock cycles the unit outputs need to settle after operands are driven (1..15).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  2  per-port request valid (bit n = port n)
req_ready  output  2  per-port request accept; at most one bit high per cycle
req_sub  input  2  per-port mode: 0 = A+B, 1 = A-B
req_a  input  2*WIDTH  per-port operand A (port n at [n*WIDTH +: WIDTH])
req_b  input  2*WIDTH  per-port operand B, same packing
au_a  output  WIDTH  operand A to shared unit
au_b  output  WIDTH  operand B to shared unit
au_sub  output  1  mode/carry-in to shared unit
au_res  input  WIDTH  shared unit result
au_cout  input  1  shared unit carry out
rsp_valid  output  2  per-port response valid
rsp_ready  input  2  per-port response accept
rsp_res  output  WIDTH  captured result (shared by both ports; qualified by rsp_valid)
rsp_cout  output  1  captured carry out

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=1 (port 0 wins the first tie), req_ready=0, rsp_valid=0, rsp_res=0, rsp_cout=0, au_a=0, au_b=0, au_sub=0, settle counter=0.
- All outputs are registered. req_ready is a registered one-cycle pulse.
- IDLE: if any req_valid is set, select a winner. With a single requester, it wins. With both requesting, the port != last_grant wins. Next cycle: req_ready[winner]=1 for exactly one cycle; latch the winner's req_a/req_b/req_sub into au_a/au_b/au_sub; set last_grant=winner; load counter=EXEC_CYCLES; go to EXEC.
- Requester contract: req_valid and operands are held stable until req_ready is seen. The block samples operands in the same edge that raises req_ready.
- EXEC: decrement the counter each cycle. When the counter reaches 1: capture au_res/au_cout into rsp_res/rsp_cout, set rsp_valid[winner]=1, go to RESP. The shared unit is therefore accessed for exactly EXEC_CYCLES cycles.
- RESP: hold rsp_valid, rsp_res and rsp_cout stable until rsp_ready[winner]=1. In that cycle, drop rsp_valid and return to IDLE. rsp_ready on the non-granted port is ignored.
- au_a/au_b/au_sub hold their last values outside EXEC (no toggling).
- Throughput: one operation per 3+EXEC_CYCLES-1 cycles minimum (arbitrate, EXEC, RESP, return to IDLE). No pipelining or overlap.
- A request that arrives during EXEC or RESP waits; it is never dropped.
- Fairness: with both ports requesting continuously, grants strictly alternate.
- A request withdrawn before req_ready is allowed: arbitration re-evaluates every IDLE cycle.
- Reset mid-operation: the transaction is aborted, no response is issued, and all state returns to reset values asynchronously.
- Width rules: rsp_res is WIDTH bits, with the unit's modular wrap (e.g. 4'hF+4'h1 = 4'h0, cout=1). Subtraction is two's complement; cout=1 means no borrow.

Optional Feature:
ADDSUB_ARB_OVF_EN
- Defined: adds output port rsp_ovf (1 bit), captured alongside rsp_res. It flags signed overflow:
  - add: operands share a sign and the result sign differs;
  - sub: operand signs differ and the result sign differs from A.
  - rsp_ovf resets to 0.
- Not defined: the port is absent and no overflow logic is built.

Test Plan:
- Reset then single port-0 request, a=4'h3, b=4'h5, sub=0, EXEC_CYCLES=1 -> req_ready[0] one pulse; rsp_valid[0] with rsp_res=4'h8, rsp_cout=0; rsp_valid[1] stays 0.
- Port 1, a=4'h3, b=4'h5, sub=1 -> rsp_res=4'hE, rsp_cout=0. Then a=4'h5, b=4'h3 -> rsp_res=4'h2, rsp_cout=1.
- Both ports request continuously for 4 operations -> grant order 0,1,0,1. Each response carries the granting port's own operands.
- Wrap: a=4'hF, b=4'h1, add -> rsp_res=4'h0, rsp_cout=1. With ADDSUB_ARB_OVF_EN, a=4'h7, b=4'h1, add -> rsp_ovf=1, rsp_res=4'h8.
- Backpressure: hold rsp_ready=0 for 5 cycles with port 1 requesting -> rsp_valid/rsp_res stable, req_ready[1] stays 0. Release -> port 1 is granted next.
- Assert rst during EXEC -> all outputs 0 immediately. No rsp_valid after deassertion. A pending request is then served from IDLE with port 0 priority.
